// File: rtl/i2c_pkg.sv
// Shared I2C constants: byte width, ACK/R-W bit levels and the target-side state encoding.
package i2c_pkg;

    localparam int DATA_SIZE = 8;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
    localparam logic [2:0] ST_RX_BYTE   = 3'd3;
    localparam logic [2:0] ST_RX_ACK    = 3'd4;
    localparam logic [2:0] ST_TX_BYTE   = 3'd5;
    localparam logic [2:0] ST_TX_ACK    = 3'd6;
    localparam logic [2:0] ST_WAIT_STOP = 3'd7;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        ADDR      = ST_ADDR,
        ADDR_ACK  = ST_ADDR_ACK,
        RX_BYTE   = ST_RX_BYTE,
        RX_ACK    = ST_RX_ACK,
        TX_BYTE   = ST_TX_BYTE,
        TX_ACK    = ST_TX_ACK,
        WAIT_STOP = ST_WAIT_STOP
    } slave_state_e;

    function automatic logic [DATA_SIZE-1:0] shift_in(input logic [DATA_SIZE-1:0] cur, input logic bit_in);
        return {cur[DATA_SIZE-2:0], bit_in};
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronisers with registered scl_rise/scl_fall/START/STOP events.
// The SDA level output is aligned with the events so a data bit can be sampled on scl_rise.
module i2c_bus_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [2:0] scl_r;
    logic [2:0] sda_r;
    logic       sda_lvl_r;
    logic       scl_rise_r;
    logic       scl_fall_r;
    logic       start_r;
    logic       stop_r;

    // Two synchroniser stages, a history stage, then registered edge/condition decode.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_r      <= 3'b000;
            sda_r      <= 3'b000;
            sda_lvl_r  <= 1'b0;
            scl_rise_r <= 1'b0;
            scl_fall_r <= 1'b0;
            start_r    <= 1'b0;
            stop_r     <= 1'b0;
        end else begin
            scl_r      <= {scl_r[1:0], i_scl};
            sda_r      <= {sda_r[1:0], i_sda};
            sda_lvl_r  <= sda_r[1];
            scl_rise_r <= scl_r[1] & ~scl_r[2];
            scl_fall_r <= ~scl_r[1] & scl_r[2];
            start_r    <= scl_r[1] & scl_r[2] & ~sda_r[1] & sda_r[2];
            stop_r     <= scl_r[1] & scl_r[2] & sda_r[1] & ~sda_r[2];
        end
    end

    assign o_sda      = sda_lvl_r;
    assign o_scl_rise = scl_rise_r;
    assign o_scl_fall = scl_fall_r;
    assign o_start    = start_r;
    assign o_stop     = stop_r;

endmodule

// File: rtl/i2c_slave.sv
// I2C target endpoint: 7-bit address match, byte receive/transmit, open-drain SDA, no clock stretching.
// Define I2C_SLAVE_GENERAL_CALL_EN to also accept the general-call address (7'h00, write only).
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_scl,
    inout  wire                  io_sda,
    input  logic [DATA_SIZE-1:0] i_tx_data,
    input  logic                 i_rx_nack,
    output logic [DATA_SIZE-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_tx_req,
    output logic                 o_busy
);

    logic sda_s;
    logic scl_rise_s;
    logic scl_fall_s;
    logic start_s;
    logic stop_s;
    logic tx_req_s;

    slave_state_e         state_r;
    logic [3:0]           bit_cnt_r;
    logic [DATA_SIZE-1:0] shift_r;
    logic                 rw_r;
    logic                 slot_r;
    logic                 nack_r;
    logic                 sda_drive_r;
    logic [DATA_SIZE-1:0] rx_data_r;
    logic                 rx_valid_r;
    logic                 busy_r;

    i2c_bus_sync u_sync (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_scl      (i_scl),
        .i_sda      (io_sda),
        .o_sda      (sda_s),
        .o_scl_rise (scl_rise_s),
        .o_scl_fall (scl_fall_s),
        .o_start    (start_s),
        .o_stop     (stop_s)
    );

    function automatic logic addr_match(input logic [DATA_SIZE-1:0] addr_byte);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
        return (addr_byte[7:1] == SLAVE_ADDR) || (addr_byte == 8'h00);
`else
        return (addr_byte[7:1] == SLAVE_ADDR);
`endif
    endfunction

    // Byte request coincides with the scl_fall that must put the new MSB on the bus.
    always_comb begin
        tx_req_s = 1'b0;
        if (scl_fall_s && !start_s && !stop_s) begin
            case (state_r)
                ADDR_ACK: tx_req_s = slot_r && (rw_r == RW_READ);
                TX_ACK:   tx_req_s = slot_r;
                default:  tx_req_s = 1'b0;
            endcase
        end else begin
            tx_req_s = 1'b0;
        end
    end

    // Protocol FSM; slot_r marks "ACK slot open" in ADDR_ACK/RX_ACK and "master ACKed" in TX_ACK.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= IDLE;
            bit_cnt_r   <= 4'd0;
            shift_r     <= 8'h00;
            rw_r        <= 1'b0;
            slot_r      <= 1'b0;
            nack_r      <= 1'b0;
            sda_drive_r <= 1'b0;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            if (start_s) begin
                state_r     <= ADDR;
                bit_cnt_r   <= 4'd0;
                busy_r      <= 1'b0;
                sda_drive_r <= 1'b0;
                slot_r      <= 1'b0;
            end else if (stop_s) begin
                state_r     <= IDLE;
                busy_r      <= 1'b0;
                sda_drive_r <= 1'b0;
                slot_r      <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: sda_drive_r <= 1'b0;
                    ADDR: if (scl_rise_s) begin
                        shift_r   <= shift_in(shift_r, sda_s);
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'd7) begin
                            rw_r   <= sda_s;
                            slot_r <= 1'b0;
                            if (addr_match(shift_in(shift_r, sda_s))) begin
                                busy_r  <= 1'b1;
                                state_r <= ADDR_ACK;
                            end else begin
                                sda_drive_r <= 1'b0;
                                state_r     <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: if (scl_fall_s) begin
                        if (!slot_r) begin
                            slot_r      <= 1'b1;
                            sda_drive_r <= 1'b1;
                        end else begin
                            slot_r    <= 1'b0;
                            bit_cnt_r <= 4'd0;
                            if (rw_r == RW_READ) begin
                                shift_r     <= i_tx_data;
                                sda_drive_r <= ~i_tx_data[DATA_SIZE-1];
                                state_r     <= TX_BYTE;
                            end else begin
                                sda_drive_r <= 1'b0;
                                state_r     <= RX_BYTE;
                            end
                        end
                    end
                    RX_BYTE: if (scl_rise_s) begin
                        shift_r   <= shift_in(shift_r, sda_s);
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'd7) begin
                            rx_data_r  <= shift_in(shift_r, sda_s);
                            rx_valid_r <= 1'b1;
                            slot_r     <= 1'b0;
                            state_r    <= RX_ACK;
                        end
                    end
                    RX_ACK: if (scl_fall_s) begin
                        if (!slot_r) begin
                            slot_r      <= 1'b1;
                            nack_r      <= i_rx_nack;
                            sda_drive_r <= (i_rx_nack == ACK);
                        end else begin
                            slot_r      <= 1'b0;
                            sda_drive_r <= 1'b0;
                            bit_cnt_r   <= 4'd0;
                            state_r     <= nack_r ? WAIT_STOP : RX_BYTE;
                        end
                    end
                    TX_BYTE: if (scl_rise_s) begin
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                    end else if (scl_fall_s) begin
                        if (bit_cnt_r == 4'd8) begin
                            sda_drive_r <= 1'b0;
                            slot_r      <= 1'b0;
                            state_r     <= TX_ACK;
                        end else begin
                            shift_r     <= {shift_r[DATA_SIZE-2:0], 1'b0};
                            sda_drive_r <= ~shift_r[DATA_SIZE-2];
                        end
                    end
                    TX_ACK: if (scl_rise_s) begin
                        if (sda_s == ACK) begin
                            slot_r <= 1'b1;
                        end else begin
                            state_r <= WAIT_STOP;
                        end
                    end else if (scl_fall_s && slot_r) begin
                        slot_r      <= 1'b0;
                        bit_cnt_r   <= 4'd0;
                        shift_r     <= i_tx_data;
                        sda_drive_r <= ~i_tx_data[DATA_SIZE-1];
                        state_r     <= TX_BYTE;
                    end
                    WAIT_STOP: sda_drive_r <= 1'b0;
                    default: begin
                        sda_drive_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                endcase
            end
        end
    end

    assign io_sda     = sda_drive_r ? 1'b0 : 1'bz;
    assign o_rx_data  = rx_data_r;
    assign o_rx_valid = rx_valid_r;
    assign o_tx_req   = tx_req_s;
    assign o_busy     = busy_r;

endmodule
